// File: rtl/ntp_sync_scheduler.sv
// Sequencer for the NTP time-set block: boot/periodic/manual sync attempts,
// timeout supervision with peer reset, epoch sanity check and retry back-off.
module ntp_sync_scheduler #(
  parameter int unsigned TICK_CYCLES   = 50000000,
  parameter int unsigned BOOT_DELAY_S  = 2,
  parameter int unsigned TIMEOUT_S     = 30,
  parameter int unsigned RETRY_DELAY_S = 5,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned SYNC_PERIOD_S = 3600,
  parameter int unsigned RST_CYCLES    = 16,
  parameter logic [31:0] MIN_EPOCH     = 32'd1704067200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        manual_req_i,
  output logic        sync_en_o,
  output logic        sync_rst_n_o,
  input  logic        sync_finished_i,
  input  logic [31:0] sync_time_i,
  output logic        time_load_o,
  output logic [31:0] time_value_o,
  output logic        busy_o,
  output logic        sync_ok_o,
  output logic        sync_fail_o,
  output logic [3:0]  retry_cnt_o
);

  localparam logic [63:0] BOOT_CYC   = 64'(BOOT_DELAY_S)  * 64'(TICK_CYCLES);
  localparam logic [63:0] TO_CYC     = 64'(TIMEOUT_S)     * 64'(TICK_CYCLES);
  localparam logic [63:0] RETRY_CYC  = 64'(RETRY_DELAY_S) * 64'(TICK_CYCLES);
  localparam logic [63:0] PERIOD_CYC = 64'(SYNC_PERIOD_S) * 64'(TICK_CYCLES);
  localparam logic [63:0] RST_CYC    = 64'(RST_CYCLES);

  typedef enum logic [2:0] {
    S_BOOT, S_ARM, S_WAIT, S_CHECK, S_RSTP, S_BACKOFF, S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] tmr_q;
  logic [3:0]  retry_q;
  logic [31:0] cand_q;
  logic [31:0] tv_q;
  logic        has_prev_q;
  logic        sync_ok_q;
  logic        sync_en_q, sync_rst_n_q, time_load_q, sync_fail_q, busy_q;

  logic accept, fail, give_up, hold_manual, cnt_en;

  assign give_up     = ({1'b0, retry_q} + 5'd1) >= 5'(MAX_RETRY);
  assign hold_manual = (state_q == S_HOLD) && enable_i && manual_req_i;
  // Idle-type states pause with the enable switch; an attempt in flight never does.
  assign cnt_en      = (state_q == S_WAIT) || (state_q == S_RSTP) ||
                       (enable_i && ((state_q == S_BOOT) || (state_q == S_HOLD) ||
                                     (state_q == S_BACKOFF)));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    fail    = 1'b0;
    case (state_q)
      S_BOOT:    if (enable_i && (manual_req_i || tmr_q == BOOT_CYC - 64'd1)) state_d = S_ARM;
      S_ARM:     state_d = S_WAIT;
      S_WAIT: begin
        if (sync_finished_i)                state_d = S_CHECK;
        else if (tmr_q == TO_CYC - 64'd1)   state_d = S_RSTP;
      end
      S_RSTP:    if (tmr_q == RST_CYC - 64'd1) fail = 1'b1;
      S_CHECK: begin
        if (cand_q >= MIN_EPOCH && (!has_prev_q || cand_q >= tv_q)) begin
          accept  = 1'b1;
          state_d = S_HOLD;
        end else begin
          fail = 1'b1;
        end
      end
      S_BACKOFF: if (enable_i && tmr_q == RETRY_CYC - 64'd1) state_d = S_ARM;
      S_HOLD:    if (hold_manual || (enable_i && tmr_q == PERIOD_CYC - 64'd1)) state_d = S_ARM;
      default:   state_d = S_BOOT;
    endcase
    if (fail) state_d = give_up ? S_HOLD : S_BACKOFF;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_BOOT;
      tmr_q        <= '0;
      retry_q      <= '0;
      cand_q       <= '0;
      tv_q         <= '0;
      has_prev_q   <= 1'b0;
      sync_ok_q    <= 1'b0;
      sync_en_q    <= 1'b0;
      sync_rst_n_q <= 1'b0;
      time_load_q  <= 1'b0;
      sync_fail_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) tmr_q <= '0;
      else if (cnt_en)        tmr_q <= tmr_q + 64'd1;

      if (state_q == S_WAIT && sync_finished_i) cand_q <= sync_time_i;

      if (accept) begin
        tv_q       <= cand_q;
        has_prev_q <= 1'b1;
        sync_ok_q  <= 1'b1;
        retry_q    <= '0;
      end else if (fail) begin
        retry_q <= give_up ? 4'd0 : retry_q + 4'd1;
      end else if (hold_manual) begin
        retry_q <= '0;
      end

      sync_en_q    <= (state_d == S_ARM);
      sync_rst_n_q <= (state_d != S_RSTP);
      time_load_q  <= accept;
      sync_fail_q  <= fail && give_up;
      busy_q       <= (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_CHECK) ||
                      (state_d == S_RSTP) || (state_d == S_BACKOFF);
    end
  end

  assign sync_en_o    = sync_en_q;
  assign sync_rst_n_o = sync_rst_n_q;
  assign time_load_o  = time_load_q;
  assign time_value_o = tv_q;
  assign busy_o       = busy_q;
  assign sync_ok_o    = sync_ok_q;
  assign sync_fail_o  = sync_fail_q;
  assign retry_cnt_o  = retry_q;

endmodule
